hack_alu_arb: RTL and testbench

Two-requester arbiter and two-stage pipeline in front of a single Hack ALU datapath (zx/nx/zy/ny/f/no function set over 16-bit operands). Shares one ALU between two independent requesters, such as the CPU execute path and a debug/test port, with valid/ready handshakes on both sides. Results return in order with the winning requester's id and the zr/ng flags. It sits between the requesters and the combinational ALU; it owns all sequencing, stalling and result buffering.

---
 rtl/hack_alu_arb.sv | 172 +++++++++++++++++
 tb/tb_hack_alu_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hack_alu_arb.sv
// hack_alu_arb
//   Shares one combinational Hack ALU (zx/nx/zy/ny/f/no) between two
//   requesters. Stage S1 holds the accepted operands and stage S2 holds
//   the computed result. Results leave in acceptance order, tagged with
//   the id of the requester that issued them.
//
// Configuration macro:
//   HACK_ALU_ARB_RR_EN  defined   -> round-robin arbitration on contest
//                       undefined -> fixed priority, port 0 wins
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   req0_valid/ready/x/y/op          requester 0 handshake and operands
//   req1_valid/ready/x/y/op          requester 1 handshake and operands
//   resp_valid/ready                 result handshake toward the consumer
//   resp_id, resp_out, resp_zr/ng    result tag, value and flags
module hack_alu_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [5:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [5:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_out,
  output logic             resp_zr,
  output logic             resp_ng
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic [5:0]       s1_op_q, s1_op_d;
  logic             s1_id_q, s1_id_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_out_q, s2_out_d;
  logic             s2_zr_q, s2_zr_d;
  logic             s2_ng_q, s2_ng_d;
  logic             s2_id_q, s2_id_d;

  logic             s2_free, s1_free;
  logic             grant;
  logic             accept;
  logic             s2_load;
  logic [WIDTH-1:0] alu_out;

  assign s2_free = !s2_valid_q || resp_ready;
  assign s1_free = !s1_valid_q || s2_free;
  assign s2_load = s1_valid_q && s2_free;

`ifdef HACK_ALU_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // On a contest the port that did not win the last transfer goes first.
  always_comb begin
    if (req0_valid && req1_valid) grant = !last_grant_q;
    else                          grant = req1_valid && !req0_valid;
  end

  // Only real transfers move the round-robin pointer; stalled contests don't.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = grant;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    grant = !req0_valid && req1_valid;
  end
`endif

  // Readies are forced low during reset so nothing is taken on that edge.
  assign req0_ready = !reset && s1_free && (grant == 1'b0);
  assign req1_ready = !reset && s1_free && (grant == 1'b1);
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Hack ALU over the S1 operands.
  always_comb begin
    logic [WIDTH-1:0] xa, ya, o;
    xa = s1_op_q[5] ? '0 : s1_x_q;
    xa = s1_op_q[4] ? ~xa : xa;
    ya = s1_op_q[3] ? '0 : s1_y_q;
    ya = s1_op_q[2] ? ~ya : ya;
    o  = s1_op_q[1] ? (xa + ya) : (xa & ya);
    alu_out = s1_op_q[0] ? ~o : o;
  end

  // S1: load from the granted port, otherwise drain into S2 when it frees up.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_op_d    = s1_op_q;
    s1_id_d    = s1_id_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_id_d    = grant;
      s1_x_d     = grant ? req1_x  : req0_x;
      s1_y_d     = grant ? req1_y  : req0_y;
      s1_op_d    = grant ? req1_op : req0_op;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2: result data only changes when a new result loads, so resp_* stay
  // stable while the consumer stalls and after the last result drains.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_out_d   = s2_out_q;
    s2_zr_d    = s2_zr_q;
    s2_ng_d    = s2_ng_q;
    s2_id_d    = s2_id_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_out_d   = alu_out;
      s2_zr_d    = (alu_out == '0);
      s2_ng_d    = alu_out[WIDTH-1];
      s2_id_d    = s1_id_q;
    end else if (s2_valid_q && resp_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_op_q    <= '0;
      s1_id_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_out_q   <= '0;
      s2_zr_q    <= 1'b0;
      s2_ng_q    <= 1'b0;
      s2_id_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_op_q    <= s1_op_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_out_q   <= s2_out_d;
      s2_zr_q    <= s2_zr_d;
      s2_ng_q    <= s2_ng_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign resp_valid = s2_valid_q;
  assign resp_out   = s2_out_q;
  assign resp_zr    = s2_zr_q;
  assign resp_ng    = s2_ng_q;
  assign resp_id    = s2_id_q;

endmodule

// File: tb/tb_hack_alu_arb.sv
// Directed testbench for hack_alu_arb. Inputs change on the falling edge
// and outputs are sampled 1 time unit later, away from the rising edge.
module tb_hack_alu_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic [5:0]  req0_op = '0, req1_op = '0;
  logic        resp_valid, resp_ready = 1'b1;
  logic        resp_id, resp_zr, resp_ng;
  logic [15:0] resp_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hack_alu_arb #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_out(resp_out),
    .resp_zr(resp_zr), .resp_ng(resp_ng)
  );

  // Two reset cycles, ending with all inputs idle just after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req0_ready got %b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req1_ready got %b want 0", req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_resp_out got %h want 0000", resp_out); end
    checks++; if (resp_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_id got %b want 0", resp_id); end
    checks++; if (resp_zr !== 1'b0 || resp_ng !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got zr=%b ng=%b want 0 0", resp_zr, resp_ng); end
  endtask

  // Single isolated operations; the response must appear two falling edges
  // after the request was presented.
  task automatic test_alu_ops();
    logic        v_port [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] v_x    [5] = '{16'h1234, 16'h0003, 16'h0003, 16'h00FF, 16'hFFFF};
    logic [15:0] v_y    [5] = '{16'h5678, 16'h0005, 16'h0005, 16'h0000, 16'h0001};
    logic [5:0]  v_op   [5] = '{6'h2A, 6'h02, 6'h13, 6'h0D, 6'h02};
    logic [15:0] v_out  [5] = '{16'h0000, 16'h0008, 16'hFFFE, 16'hFF00, 16'h0000};
    logic        v_zr   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        v_ng   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (v_port[i]) begin
        req1_valid = 1'b1; req1_x = v_x[i]; req1_y = v_y[i]; req1_op = v_op[i];
      end else begin
        req0_valid = 1'b1; req0_x = v_x[i]; req0_y = v_y[i]; req0_op = v_op[i];
      end
      #1;
      checks++;
      if ((v_port[i] ? req1_ready : req0_ready) !== 1'b1) begin
        errors++; $display("[TB] FAIL op%0d_ready got %b want 1", i, v_port[i] ? req1_ready : req0_ready);
      end
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL op%0d_early_valid got %b want 0", i, resp_valid); end
      @(negedge clk);
      #1;
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL op%0d_valid got %b want 1", i, resp_valid); end
      checks++; if (resp_out !== v_out[i]) begin errors++; $display("[TB] FAIL op%0d_out got %h want %h", i, resp_out, v_out[i]); end
      checks++; if (resp_zr !== v_zr[i]) begin errors++; $display("[TB] FAIL op%0d_zr got %b want %b", i, resp_zr, v_zr[i]); end
      checks++; if (resp_ng !== v_ng[i]) begin errors++; $display("[TB] FAIL op%0d_ng got %b want %b", i, resp_ng, v_ng[i]); end
      checks++; if (resp_id !== v_port[i]) begin errors++; $display("[TB] FAIL op%0d_id got %b want %b", i, resp_id, v_port[i]); end
    end
  endtask

  // Both ports valid for four back-to-back transfers. Op 0x0C passes x
  // through (y forced to all-ones, AND), so each result identifies its port.
  task automatic test_contention();
`ifdef HACK_ALU_ARB_RR_EN
    logic exp_gnt [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    logic exp_gnt [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    logic [15:0] exp_out;
    do_reset();
    req0_x = 16'h1111; req0_y = 16'h0000; req0_op = 6'h0C;
    req1_x = 16'h2222; req1_y = 16'h0000; req1_op = 6'h0C;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req0_valid = (c < 4);
      req1_valid = (c < 4);
      #1;
      if (c < 4) begin
        checks++; if (req0_ready !== !exp_gnt[c]) begin errors++; $display("[TB] FAIL contend%0d_req0_ready got %b want %b", c, req0_ready, !exp_gnt[c]); end
        checks++; if (req1_ready !== exp_gnt[c]) begin errors++; $display("[TB] FAIL contend%0d_req1_ready got %b want %b", c, req1_ready, exp_gnt[c]); end
      end
      if (c == 1) begin
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL contend_early_valid got %b want 0", resp_valid); end
      end
      if (c >= 2) begin
        exp_out = exp_gnt[c-2] ? 16'h2222 : 16'h1111;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL contend_resp%0d_valid got %b want 1", c-2, resp_valid); end
        checks++; if (resp_id !== exp_gnt[c-2]) begin errors++; $display("[TB] FAIL contend_resp%0d_id got %b want %b", c-2, resp_id, exp_gnt[c-2]); end
        checks++; if (resp_out !== exp_out) begin errors++; $display("[TB] FAIL contend_resp%0d_out got %h want %h", c-2, resp_out, exp_out); end
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Port 0 streams with a new x every cycle while the consumer stalls; only
  // the first two are taken, and they drain in order once resp_ready rises.
  task automatic test_backpressure();
    do_reset();
    resp_ready = 1'b0;
    req0_y = 16'h0000; req0_op = 6'h0C;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req0_x = 16'h0A00 + 16'(c);
      #1;
      checks++; if (req0_ready !== (c < 2)) begin errors++; $display("[TB] FAIL bp%0d_req0_ready got %b want %b", c, req0_ready, (c < 2)); end
      if (c >= 2) begin
        checks++; if (resp_valid !== 1'b1 || resp_out !== 16'h0A00) begin errors++; $display("[TB] FAIL bp%0d_hold got v=%b out=%h want v=1 out=0a00", c, resp_valid, resp_out); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp%0d_req1_ready got %b want 0", c, req1_ready); end
      end
    end
    @(negedge clk);
    req0_valid = 1'b0;
    resp_ready = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_out !== 16'h0A00) begin errors++; $display("[TB] FAIL bp_drain0 got v=%b out=%h want v=1 out=0a00", resp_valid, resp_out); end
    @(negedge clk);
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_out !== 16'h0A01) begin errors++; $display("[TB] FAIL bp_drain1 got v=%b out=%h want v=1 out=0a01", resp_valid, resp_out); end
    @(negedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain_done got %b want 0", resp_valid); end
  endtask

  // Fill both stages, assert reset, then confirm outputs are back at reset
  // values and a fresh request still completes.
  task automatic test_reset_midflight();
    do_reset();
    resp_ready = 1'b0;
    req1_x = 16'h8001; req1_y = 16'h0000; req1_op = 6'h0C;
    @(negedge clk);
    req1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_out !== 16'h8001 || resp_ng !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_full got v=%b out=%h ng=%b rdy=%b want 1 8001 1 0", resp_valid, resp_out, resp_ng, req1_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    resp_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ready got %b want 0", req1_ready); end
    @(negedge clk);
    reset = 1'b0;
    req1_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || resp_out !== 16'h0000 || resp_id !== 1'b0 || resp_zr !== 1'b0 || resp_ng !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_after_reset got v=%b out=%h id=%b zr=%b ng=%b want all 0", resp_valid, resp_out, resp_id, resp_zr, resp_ng);
    end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_flushed got %b want 0", resp_valid); end
    req1_x = 16'h0003; req1_y = 16'h0005; req1_op = 6'h02;
    req1_valid = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_out !== 16'h0008 || resp_id !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_new_op got v=%b out=%h id=%b want 1 0008 1", resp_valid, resp_out, resp_id);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_contention();
    test_backpressure();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends even if a task hangs.
  initial begin
    #100000;
    $display("[TB] FAIL timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
